// File: rtl/bfly_twiddle_mul_pkg.sv
// bfly_twiddle_mul_pkg: shared FFT sample type and fixed-point rounding/saturation helpers
package bfly_twiddle_mul_pkg;

    localparam int MAX_W = 32;

    typedef struct packed {
        logic signed [MAX_W-1:0] re;
        logic signed [MAX_W-1:0] im;
    } cplx_t;

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] lim;
        lim = 64'sd1 <<< (w - 1);
        return x >= lim ? lim - 64'sd1 : (x < -lim ? -lim : x);
    endfunction

    function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] x, input int frac);
        return (x + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/bfly_twiddle_mul_if.sv
// bfly_twiddle_mul_if: butterfly sum/diff input bus and merged output stream
interface bfly_twiddle_mul_if #(
    parameter int WIDTH    = 12,
    parameter int NUM_PAIR = 16
);
    localparam int IW = $clog2(NUM_PAIR);

    logic                  sum_valid;
    logic                  diff_valid;
    logic                  twiddle_valid;
    logic signed [WIDTH:0] bfly_sum_re;
    logic signed [WIDTH:0] bfly_sum_im;
    logic signed [WIDTH:0] bfly_diff_re;
    logic signed [WIDTH:0] bfly_diff_im;
    logic                  dout_valid;
    logic                  dout_is_diff;
    logic [IW-1:0]         dout_idx;
    logic signed [WIDTH:0] dout_re;
    logic signed [WIDTH:0] dout_im;
    logic                  blk_done;
    logic                  proto_err;

    modport master (
        output sum_valid, diff_valid, twiddle_valid,
        output bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im,
        input  dout_valid, dout_is_diff, dout_idx, dout_re, dout_im, blk_done, proto_err
    );

    modport slave (
        input  sum_valid, diff_valid, twiddle_valid,
        input  bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im,
        output dout_valid, dout_is_diff, dout_idx, dout_re, dout_im, blk_done, proto_err
    );

endinterface

// File: rtl/twiddle_rom.sv
// twiddle_rom: W_(2*NUM_PAIR)^k in Q1.(TW_WIDTH-2), table built at elaboration
module twiddle_rom #(
    parameter int NUM_PAIR = 16,
    parameter int TW_WIDTH = 10
) (
    input  logic [$clog2(NUM_PAIR)-1:0] k,
    output logic signed [TW_WIDTH-1:0]  tw_re,
    output logic signed [TW_WIDTH-1:0]  tw_im
);

    localparam int  TW_FRAC = TW_WIDTH - 2;
    localparam real PI      = 3.14159265358979323846;

    // round half away from zero so the table is symmetric about the axes
    function automatic logic signed [TW_WIDTH-1:0] tw_val(input int idx, input bit imag);
        real v;
        v = imag ? -$sin(PI * idx / NUM_PAIR) : $cos(PI * idx / NUM_PAIR);
        v = v * (2.0 ** TW_FRAC);
        return TW_WIDTH'(v < 0.0 ? -$rtoi(0.5 - v) : $rtoi(v + 0.5));
    endfunction

    logic signed [TW_WIDTH-1:0] rom_re [NUM_PAIR];
    logic signed [TW_WIDTH-1:0] rom_im [NUM_PAIR];

    for (genvar i = 0; i < NUM_PAIR; i++) begin : g_rom
        localparam logic signed [TW_WIDTH-1:0] RE = tw_val(i, 1'b0);
        localparam logic signed [TW_WIDTH-1:0] IM = tw_val(i, 1'b1);
        assign rom_re[i] = RE;
        assign rom_im[i] = IM;
    end

    assign tw_re = rom_re[k];
    assign tw_im = rom_im[k];

endmodule

// File: rtl/bfly_twiddle_mul.sv
// bfly_twiddle_mul: passes butterfly sums, twiddles diffs, merges both into one 2-cycle stream
module bfly_twiddle_mul
    import bfly_twiddle_mul_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int NUM_PAIR = 16,
    parameter int TW_WIDTH = 10
) (
    input  logic             clk,
    input  logic             rstn,
    bfly_twiddle_mul_if.slave bus
);

    localparam int SW      = WIDTH + 1;
    localparam int PW      = SW + TW_WIDTH;
    localparam int TW_FRAC = TW_WIDTH - 2;
    localparam int IW      = $clog2(NUM_PAIR);

    logic [IW-1:0]              sum_cnt, k;
    logic signed [TW_WIDTH-1:0] tw_re, tw_im;
    logic                       clash, sum_acc, diff_acc, blk_ok;
    logic                       v1, is_diff1, done1;
    logic [IW-1:0]              idx1;
    logic signed [PW-1:0]       ac, bd, ad, bc;
    cplx_t                      sum1;
    logic signed [PW:0]         re_full, im_full;
    logic signed [SW-1:0]       re_out, im_out;

    twiddle_rom #(.NUM_PAIR(NUM_PAIR), .TW_WIDTH(TW_WIDTH)) u_rom (
        .k    (k),
        .tw_re(tw_re),
        .tw_im(tw_im)
    );

    // sums also pass the clamp; it is an identity for in-range samples
    always_comb begin
        clash    = bus.sum_valid && bus.diff_valid;
        sum_acc  = bus.sum_valid && !bus.diff_valid;
        diff_acc = bus.diff_valid && !bus.sum_valid;
        blk_ok   = k == '0 && sum_cnt == '0;
        re_full  = (PW+1)'(ac) - (PW+1)'(bd);
        im_full  = (PW+1)'(ad) + (PW+1)'(bc);
        re_out   = SW'(sat(is_diff1 ? rnd_shr(64'(re_full), TW_FRAC) : 64'(sum1.re), SW));
        im_out   = SW'(sat(is_diff1 ? rnd_shr(64'(im_full), TW_FRAC) : 64'(sum1.im), SW));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_cnt          <= '0;
            k                <= '0;
            v1               <= 1'b0;
            is_diff1         <= 1'b0;
            idx1             <= '0;
            done1            <= 1'b0;
            ac               <= '0;
            bd               <= '0;
            ad               <= '0;
            bc               <= '0;
            sum1             <= '0;
            bus.dout_valid   <= 1'b0;
            bus.dout_is_diff <= 1'b0;
            bus.dout_idx     <= '0;
            bus.dout_re      <= '0;
            bus.dout_im      <= '0;
            bus.blk_done     <= 1'b0;
            bus.proto_err    <= 1'b0;
        end else begin
            if (sum_acc)
                sum_cnt <= sum_cnt == IW'(NUM_PAIR - 1) ? '0 : sum_cnt + 1'b1;
            if (diff_acc)
                k <= k == IW'(NUM_PAIR - 1) ? '0 : k + 1'b1;
            v1               <= sum_acc || diff_acc;
            is_diff1         <= diff_acc;
            idx1             <= diff_acc ? k : sum_cnt;
            done1            <= bus.twiddle_valid && blk_ok;
            ac               <= PW'(bus.bfly_diff_re) * PW'(tw_re);
            bd               <= PW'(bus.bfly_diff_im) * PW'(tw_im);
            ad               <= PW'(bus.bfly_diff_re) * PW'(tw_im);
            bc               <= PW'(bus.bfly_diff_im) * PW'(tw_re);
            sum1             <= '{re: MAX_W'(bus.bfly_sum_re), im: MAX_W'(bus.bfly_sum_im)};
            bus.dout_valid   <= v1;
            bus.dout_is_diff <= v1 && is_diff1;
            bus.dout_idx     <= v1 ? idx1 : '0;
            bus.dout_re      <= v1 ? re_out : '0;
            bus.dout_im      <= v1 ? im_out : '0;
            bus.blk_done     <= done1;
            if (clash || (bus.twiddle_valid && !blk_ok))
                bus.proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bfly_twiddle_mul.sv
// tb_bfly_twiddle_mul: directed and random stimulus against a cycle-level arithmetic reference
module tb_bfly_twiddle_mul;

    localparam int  WIDTH    = 12;
    localparam int  NUM_PAIR = 16;
    localparam int  TW_WIDTH = 10;
    localparam int  SW       = WIDTH + 1;
    localparam real PI       = 3.14159265358979323846;
    localparam real SCALE    = 256.0;

    typedef struct {
        bit v;
        bit d;
        bit done;
        int idx;
        int re;
        int im;
    } out_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    out_t nxt, expo;
    int   m_sum, m_k;
    bit   m_err;

    bfly_twiddle_mul_if #(.WIDTH(WIDTH), .NUM_PAIR(NUM_PAIR)) bus ();

    bfly_twiddle_mul #(.WIDTH(WIDTH), .NUM_PAIR(NUM_PAIR), .TW_WIDTH(TW_WIDTH)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int rnd(input real x);
        return x < 0.0 ? -$rtoi(0.5 - x) : $rtoi(x + 0.5);
    endfunction

    // exact complex product, then round half up and clamp to the sample range
    function automatic int q(input longint p);
        int r;
        r = $rtoi($floor((p + SCALE / 2.0) / SCALE));
        return r > 4095 ? 4095 : (r < -4096 ? -4096 : r);
    endfunction

    function automatic out_t predict(input bit sv, input bit dv, input bit tv,
                                     input int sre, input int sim, input int dre, input int dim,
                                     input int sc, input int kc);
        out_t o = '{default: 0};
        int c = rnd(SCALE * $cos(PI * kc / NUM_PAIR));
        int d = rnd(-SCALE * $sin(PI * kc / NUM_PAIR));
        o.done = tv && sc == 0 && kc == 0;
        if (sv && !dv) begin
            o.v = 1; o.idx = sc; o.re = sre; o.im = sim;
        end else if (dv && !sv) begin
            o.v = 1; o.d = 1; o.idx = kc;
            o.re = q(longint'(dre) * c - longint'(dim) * d);
            o.im = q(longint'(dre) * d + longint'(dim) * c);
        end
        return o;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            expo  <= '{default: 0};
            nxt   <= '{default: 0};
            m_sum <= 0;
            m_k   <= 0;
            m_err <= 0;
        end else begin
            expo <= nxt;
            nxt  <= predict(bus.sum_valid, bus.diff_valid, bus.twiddle_valid,
                            int'(bus.bfly_sum_re), int'(bus.bfly_sum_im),
                            int'(bus.bfly_diff_re), int'(bus.bfly_diff_im), m_sum, m_k);
            if (bus.sum_valid && !bus.diff_valid) m_sum <= (m_sum + 1) % NUM_PAIR;
            if (bus.diff_valid && !bus.sum_valid) m_k <= (m_k + 1) % NUM_PAIR;
            if ((bus.sum_valid && bus.diff_valid) || (bus.twiddle_valid && (m_k != 0 || m_sum != 0)))
                m_err <= 1;
        end
    end

    always @(negedge clk) begin
        check("valid", bus.dout_valid, expo.v);
        check("is_diff", bus.dout_is_diff, expo.d);
        check("idx", bus.dout_idx, expo.idx);
        check("re", bus.dout_re, expo.re);
        check("im", bus.dout_im, expo.im);
        check("blk_done", bus.blk_done, expo.done);
        check("proto_err", bus.proto_err, m_err);
    end

    task automatic drive(input bit sv, input bit dv, input bit tv,
                         input int sre, input int sim, input int dre, input int dim);
        bus.sum_valid     = sv;
        bus.diff_valid    = dv;
        bus.twiddle_valid = tv;
        bus.bfly_sum_re   = SW'(sre);
        bus.bfly_sum_im   = SW'(sim);
        bus.bfly_diff_re  = SW'(dre);
        bus.bfly_diff_im  = SW'(dim);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int rs();
        return $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) ? 4095 : -4096)
                                         : int'($urandom_range(0, 8191)) - 4096;
    endfunction

    task automatic rnd_diffs(input int n);
        repeat (n) drive(0, 1, 0, 0, 0, rs(), rs());
    endtask

    initial begin
        bus.sum_valid = 0; bus.diff_valid = 0; bus.twiddle_valid = 0;
        bus.bfly_sum_re = '0; bus.bfly_sum_im = '0; bus.bfly_diff_re = '0; bus.bfly_diff_im = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.dout_valid, 0);
        check("rst_perr", bus.proto_err, 0);
        rstn = 1;
        drive(0, 1, 0, 0, 0, 100, -50);
        idle(1);
        check("k0_re", bus.dout_re, 100);
        check("k0_im", bus.dout_im, -50);
        check("k0_diff", bus.dout_is_diff, 1);
        check("k0_idx", bus.dout_idx, 0);
        rnd_diffs(3);
        drive(0, 1, 0, 0, 0, -4096, -4096);
        idle(1);
        check("sat_re", bus.dout_re, -4096);
        check("sat_im", bus.dout_im, 0);
        rnd_diffs(3);
        drive(0, 1, 0, 0, 0, 100, -50);
        idle(1);
        check("k8_re", bus.dout_re, -50);
        check("k8_im", bus.dout_im, -100);
        check("k8_idx", bus.dout_idx, 8);
        rnd_diffs(7);
        for (int i = 0; i < NUM_PAIR; i++) drive(1, 0, 0, i, -i, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        idle(1);
        check("blk_pulse", bus.blk_done, 1);
        check("blk_perr", bus.proto_err, 0);
        idle(1);
        check("blk_once", bus.blk_done, 0);
        drive(1, 1, 0, 5, 5, 7, 7);
        check("clash_perr", bus.proto_err, 1);
        idle(1);
        check("clash_nout", bus.dout_valid, 0);
        drive(0, 1, 0, 0, 0, 100, -50);
        idle(1);
        check("clash_k", bus.dout_idx, 0);
        check("clash_re", bus.dout_re, 100);
        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(0, 9));
            drive(r < 4, r >= 3 && r < 8, $urandom_range(0, 19) == 0, rs(), rs(), rs(), rs());
        end
        idle(2);
        rstn = 0;
        #3;
        rstn = 1;
        rnd_diffs(5);
        #2;
        rstn = 0;
        bus.diff_valid = 0;
        #1;
        check("arst_valid", bus.dout_valid, 0);
        check("arst_re", bus.dout_re, 0);
        check("arst_idx", bus.dout_idx, 0);
        check("arst_perr", bus.proto_err, 0);
        @(posedge clk);
        #1;
        rstn = 1;
        drive(0, 1, 0, 0, 0, 100, -50);
        idle(1);
        check("arst_k0_idx", bus.dout_idx, 0);
        check("arst_k0_re", bus.dout_re, 100);
        check("arst_k0_im", bus.dout_im, -50);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bfly_twiddle_mul.md
Name: bfly_twiddle_mul

Overview:
- Downstream consumer of the radix-2 butterfly stage in the streaming FFT pipeline; the receive end of the bfly_sum/bfly_diff interface.
- Sum samples pass through unchanged with matched latency.
- Diff samples are multiplied by the twiddle factor W_(2*NUM_PAIR)^k, where k is the diff sample index in the current block. The result is rounded and saturated and presented as one merged output stream to the next FFT stage.

Parameters:
- WIDTH, 12, butterfly input width; input and output samples are WIDTH+1 bits.
- NUM_PAIR, 16, butterfly pairs per block (16, 8, 4, 2); the twiddle period is 2*NUM_PAIR.
- TW_WIDTH, 10, signed twiddle width; Q1.(TW_WIDTH-2) format, so the fractional bit count TW_FRAC = TW_WIDTH-2.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- sum_valid  in  1  bfly_sum_re/im hold a valid sum sample this cycle
- diff_valid  in  1  bfly_diff_re/im hold a valid diff sample this cycle
- bfly_sum_re  in  WIDTH+1  signed sum, real part
- bfly_sum_im  in  WIDTH+1  signed sum, imaginary part
- bfly_diff_re  in  WIDTH+1  signed diff, real part
- bfly_diff_im  in  WIDTH+1  signed diff, imaginary part
- twiddle_valid  in  1  end-of-block strobe from the butterfly
- dout_valid  out  1  output sample valid
- dout_is_diff  out  1  1 = twiddled diff sample, 0 = sum sample
- dout_idx  out  $clog2(NUM_PAIR)  sample index within its half-block
- dout_re  out  WIDTH+1  signed output, real part
- dout_im  out  WIDTH+1  signed output, imaginary part
- blk_done  out  1  one-cycle pulse after the last diff output of a block
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: all outputs 0, both counters 0, pipeline valids 0. Reset is asynchronous and may occur mid-block; on release the block restarts at k=0 with no stale outputs.
- Counters:
  - sum_cnt increments on each accepted sum_valid and wraps from NUM_PAIR-1 to 0.
  - k (diff_cnt) behaves the same on each accepted diff_valid.
- Twiddle ROM (combinational, indexed by k):
  - re = round(2^TW_FRAC * cos(pi*k/NUM_PAIR))
  - im = round(-2^TW_FRAC * sin(pi*k/NUM_PAIR))
  - k=0 gives (2^TW_FRAC, 0), which is exact.
- Pipeline, fixed latency 2 cycles from input valid to dout_valid for both paths:
  - Stage 1 registers:
    - products ac, bd, ad, bc at full width (WIDTH+1+TW_WIDTH), with a = diff_re, b = diff_im, c = tw_re, d = tw_im;
    - the sum sample;
    - the type flag and index.
  - Stage 2:
    - re = ac-bd and im = ad+bc, at full width +1 bit;
    - round half-up: add 2^(TW_FRAC-1), then arithmetic shift right by TW_FRAC;
    - saturate to the signed WIDTH+1 range [-2^WIDTH, 2^WIDTH-1];
    - register dout.
  - Sum samples bypass the multiply and are output as-is after the same 2 cycles.
- dout_re/dout_im are 0 whenever dout_valid=0.
- Back-to-back valids every cycle are supported; there is no stall or backpressure.
- Simultaneous sum_valid and diff_valid: proto_err is set, neither sample is accepted, and both counters hold.
- twiddle_valid:
  - if k=0 and sum_cnt=0 on arrival (a complete block), blk_done pulses exactly once, 2 cycles after twiddle_valid;
  - otherwise proto_err is set and no blk_done is generated.
- proto_err is cleared only by reset.

Decomposition:
- Shared FFT package holds:
  - a saturation function (width-generic signed clamp);
  - a rounding shift function;
  - a complex sample struct type.
- Sub-module twiddle_rom (params NUM_PAIR, TW_WIDTH; input k; outputs tw_re/tw_im). Values are generated by a constant function at elaboration, so there is no hard-coded table per NUM_PAIR.

Test Plan:
- Identity, k=0: diff (100,-50) with diff_valid -> 2 cycles later dout_valid=1, dout_is_diff=1, idx=0, dout=(100,-50).
- -j twiddle, NUM_PAIR=16, k=8: diff (100,-50) -> dout=(-50,-100).
- Saturation, k=4: diff (-4096,-4096), twiddle (181,-181) -> dout_re saturates to -4096, dout_im=0.
- Sum passthrough: 16 consecutive sums (i, -i), i=0..15 -> outputs identical, idx 0..15, dout_is_diff=0, latency 2.
- Full block: 16 sums, 16 diffs, then twiddle_valid -> blk_done pulses once 2 cycles later, proto_err=0, k wraps to 0.
- Errors and reset:
  - sum_valid and diff_valid high together -> proto_err=1, no output, counters unchanged;
  - rstn asserted at k=5 -> all outputs 0 immediately; next diff uses k=0.
